// File: rtl/pool_2x2_stream_if.sv
// Valid/ready stream bundle for the 2x2 pooling controller.
// Master drives pixels in and accepts pooled words; slave is the pooler.
interface pool_2x2_stream_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/pool_2x2_stream_ctrl.sv
// 2x2 stride-2 max pooling over one raster-order frame per start pulse.
// Even rows fill a half-width buffer of pair maxima; odd rows merge and emit.
module pool_2x2_stream_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    pool_2x2_stream_ctrl_if.slave bus,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LB = IMG_W / 2;
    localparam int LW = (LB > 1) ? $clog2(LB) : 1;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef enum logic [1:0] {IDLE, EVEN, ODD, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [LW-1:0] lidx;
    word_t         pair_reg;
    word_t         out_data;
    word_t         pair_max;
    word_t         win_max;
    word_t         lbuf [LB];
    logic          out_valid;
    logic          in_ready;
    logic          acc;
    logic          take;
    logic          col_last;
    logic          row_last;
    logic          pair_hi;

    function automatic word_t max2(input word_t a, input word_t b);
        return (a > b) ? a : b;
    endfunction

    // ODD rows stall input while an untaken result would be overwritten
    assign in_ready = (state == EVEN) ||
                      ((state == ODD) && (!out_valid || bus.out_ready));
    assign acc      = bus.in_valid && in_ready;
    assign take     = out_valid && bus.out_ready;
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign pair_hi  = col[0];
    assign lidx     = LW'(col >> 1);
    assign pair_max = max2(pair_reg, bus.in_data);
    assign win_max  = max2(lbuf[lidx], pair_max);

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign busy          = (state != IDLE);
    assign frame_done    = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // an odd-height frame ends on an even row, so both rows test row_last
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = EVEN;
            EVEN: if (acc && col_last) state_n = row_last ? DONE : ODD;
            ODD:  if (acc && col_last) state_n = row_last ? DONE : EVEN;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 pair_reg <= '0;
        else if (acc && !pair_hi) pair_reg <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (acc && state == EVEN && pair_hi) lbuf[lidx] <= pair_max;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (acc && state == ODD && pair_hi) begin
            out_data  <= win_max;
            out_valid <= 1'b1;
        end else if (take) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pool_2x2_stream_ctrl.sv
// Directed and randomized frames on 4x4, 4x2 and 5x5 poolers,
// checked against a window-max model of the pixel list.
module tb_pool_2x2_stream_ctrl;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    int            sel = 0;
    int            cyc = 0;
    int            n_pass = 0;
    int            n_chk = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic [2:0]    st, bsy, fd;
    logic          cur_ir, cur_ov, cur_busy, cur_fd;
    logic [DW-1:0] cur_od;
    logic [DW-1:0] pix [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    int            ref_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pool_2x2_stream_ctrl_if #(.DATA_WIDTH(DW)) if_a ();
    pool_2x2_stream_ctrl_if #(.DATA_WIDTH(DW)) if_b ();
    pool_2x2_stream_ctrl_if #(.DATA_WIDTH(DW)) if_c ();

    assign st[0] = start && (sel == 0);
    assign st[1] = start && (sel == 1);
    assign st[2] = start && (sel == 2);

    assign if_a.in_data   = in_data;
    assign if_a.in_valid  = in_valid;
    assign if_a.out_ready = out_ready;
    assign if_b.in_data   = in_data;
    assign if_b.in_valid  = in_valid;
    assign if_b.out_ready = out_ready;
    assign if_c.in_data   = in_data;
    assign if_c.in_valid  = in_valid;
    assign if_c.out_ready = out_ready;

    pool_2x2_stream_ctrl #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(4)) u_a (
        .clk(clk), .rst(rst), .start(st[0]), .bus(if_a.slave),
        .busy(bsy[0]), .frame_done(fd[0])
    );
    pool_2x2_stream_ctrl #(.DATA_WIDTH(DW), .IMG_W(4), .IMG_H(2)) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .bus(if_b.slave),
        .busy(bsy[1]), .frame_done(fd[1])
    );
    pool_2x2_stream_ctrl #(.DATA_WIDTH(DW), .IMG_W(5), .IMG_H(5)) u_c (
        .clk(clk), .rst(rst), .start(st[2]), .bus(if_c.slave),
        .busy(bsy[2]), .frame_done(fd[2])
    );

    always_comb begin
        cur_ir   = if_a.in_ready;
        cur_ov   = if_a.out_valid;
        cur_od   = if_a.out_data;
        cur_busy = bsy[0];
        cur_fd   = fd[0];
        if (sel == 1) begin
            cur_ir   = if_b.in_ready;
            cur_ov   = if_b.out_valid;
            cur_od   = if_b.out_data;
            cur_busy = bsy[1];
            cur_fd   = fd[1];
        end else if (sel == 2) begin
            cur_ir   = if_c.in_ready;
            cur_ov   = if_c.out_valid;
            cur_od   = if_c.out_data;
            cur_busy = bsy[2];
            cur_fd   = fd[2];
        end
    end

    // sole writer of the capture queue and frame_done bookkeeping
    always @(negedge clk) begin
        if (cur_ov && out_ready) got_q.push_back(cur_od);
        if (cur_fd) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_chk++;
        assert (obs === want) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    function automatic void pool_model(input int w, input int h);
        exp_q.delete();
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                logic [DW-1:0] m;
                int            b;
                b = 2 * r * w + 2 * c;
                m = pix[b];
                if (pix[b + 1] > m)     m = pix[b + 1];
                if (pix[b + w] > m)     m = pix[b + w];
                if (pix[b + w + 1] > m) m = pix[b + w + 1];
                exp_q.push_back(m);
            end
        end
    endfunction

    function automatic void ramp(input int n);
        pix.delete();
        for (int i = 0; i < n; i++) pix.push_back(DW'(i));
    endfunction

    function automatic void rand_pix(input int n);
        pix.delete();
        for (int i = 0; i < n; i++) pix.push_back(DW'($urandom));
    endfunction

    // mode 0: steady, 1: stall out_ready 5 cycles at first result, 2: random
    task automatic run_frame(input int s, input int w, input int h,
                             input int mode, input int abort_at,
                             input string tag);
        int            idx = 0;
        int            budget = 0;
        int            stall_left = 0;
        int            base;
        int            dbase;
        int            last_acc = 0;
        bit            stalled = 0;
        bit            schk;
        logic [DW-1:0] hold = '0;
        pool_model(w, h);
        sel   = s;
        base  = got_q.size();
        dbase = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk($sformatf("%s_busy_on", tag), cur_busy, 1);
        while (idx < w * h && budget < 3000) begin
            if (abort_at >= 0 && idx == abort_at) break;
            in_data  = pix[idx];
            in_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            schk     = 0;
            if (mode == 1 && !stalled && cur_ov) begin
                stalled    = 1;
                stall_left = 5;
                hold       = cur_od;
                chk($sformatf("%s_first", tag), hold, exp_q[0]);
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                schk = 1;
            end else begin
                out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            start = (mode == 2 && idx > 0 && $urandom_range(0, 7) == 0);
            @(negedge clk);
            if (schk) begin
                chk($sformatf("%s_hold_data", tag), cur_od, hold);
                chk($sformatf("%s_hold_valid", tag), cur_ov, 1);
                chk($sformatf("%s_hold_inrdy", tag), cur_ir, 0);
            end
            if (in_valid && cur_ir) begin
                idx++;
                last_acc = cyc;
            end
            @(posedge clk);
            #1 budget++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (abort_at >= 0) return;
        chk($sformatf("%s_in_count", tag), idx, w * h);
        if (mode == 1) chk($sformatf("%s_stalled", tag), stalled, 1);
        budget = 0;
        while (got_q.size() - base < exp_q.size() && budget < 300) begin
            out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            #1 budget++;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("%s_out_count", tag), got_q.size() - base,
            exp_q.size());
        foreach (exp_q[i])
            chk($sformatf("%s_out%0d", tag, i), got_q[base + i], exp_q[i]);
        chk($sformatf("%s_done_cnt", tag), done_cnt - dbase, 1);
        chk($sformatf("%s_done_time", tag), done_cyc, last_acc + 1);
        chk($sformatf("%s_busy_off", tag), cur_busy, 0);
        in_valid = 1'b1;
        @(negedge clk);
        chk($sformatf("%s_idle_inrdy", tag), cur_ir, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic chk_ref(input string tag);
        int n;
        n = got_q.size();
        foreach (ref_q[i])
            chk($sformatf("%s_ref%0d", tag, i),
                (n >= ref_q.size()) ? got_q[n - ref_q.size() + i] : '0,
                ref_q[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk($sformatf("rst%0d_inrdy", s), cur_ir, 0);
            chk($sformatf("rst%0d_ovalid", s), cur_ov, 0);
            chk($sformatf("rst%0d_odata", s), cur_od, 0);
            chk($sformatf("rst%0d_busy", s), cur_busy, 0);
            chk($sformatf("rst%0d_done", s), cur_fd, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        ramp(16);
        run_frame(0, 4, 4, 0, -1, "t1");
        ref_q = {5, 7, 13, 15};
        chk_ref("t1");

        pix = {16'd9, 16'd1, 16'd2, 16'd3, 16'd4, 16'd8, 16'd0, 16'hFFFF};
        run_frame(1, 4, 2, 0, -1, "t2");
        ref_q = {9, 'hFFFF};
        chk_ref("t2");

        ramp(16);
        run_frame(0, 4, 4, 1, -1, "t3");
        ref_q = {5, 7, 13, 15};
        chk_ref("t3");

        ramp(25);
        run_frame(2, 5, 5, 0, -1, "t4");
        ref_q = {6, 8, 16, 18};
        chk_ref("t4");

        ramp(16);
        run_frame(0, 4, 4, 0, 7, "t5a");
        rst = 1'b1;
        #1;
        chk("t5_rst_ovalid", cur_ov, 0);
        chk("t5_rst_odata", cur_od, 0);
        chk("t5_rst_busy", cur_busy, 0);
        chk("t5_rst_inrdy", cur_ir, 0);
        chk("t5_rst_done", cur_fd, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        run_frame(0, 4, 4, 0, -1, "t5b");
        ref_q = {5, 7, 13, 15};
        chk_ref("t5b");

        ramp(16);
        run_frame(0, 4, 4, 2, -1, "t6");
        ref_q = {5, 7, 13, 15};
        chk_ref("t6");

        for (int k = 0; k < 3; k++) begin
            rand_pix(16);
            run_frame(0, 4, 4, 2, -1, $sformatf("r44_%0d", k));
            rand_pix(8);
            run_frame(1, 4, 2, 2, -1, $sformatf("r42_%0d", k));
            rand_pix(25);
            run_frame(2, 5, 5, 2, -1, $sformatf("r55_%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
